lpffir_out_buf: RTL and testbench
=================================

Name: lpffir_out_buf

Overview:
Downstream stage of the linear-phase FIR core.
- Captures the filter output on each sample strobe and decimates by a runtime factor.
- Buffers kept samples in a small first-word-fall-through FIFO.
- Presents them on a valid/ready stream to the consumer, with sticky overflow reporting.

Parameters:
DW, 16, sample width; must match the filter output width.
DEPTH, 8, FIFO entries; power of two, minimum 2.
DEC_W, 4, width of the decimation factor input.

Ports:
clk_i  input  1  clock.
rstn_i  input  1  reset.
clr_i  input  1  synchronous flush: FIFO, decimation counter and overflow flag.
en_i  input  1  sample strobe; the same strobe that drives the filter core enable.
y_i  input  DW  filter output; sampled only when en_i=1.
dec_i  input  DEC_W  decimation factor; 0 or 1 = keep every sample, N = keep one in N.
m_valid_o  output  1  head-of-FIFO sample available.
m_ready_i  input  1  consumer accepts the head sample.
m_data_o  output  DW  head-of-FIFO sample.
level_o  output  $clog2(DEPTH)+1  current occupancy.
ovf_o  output  1  sticky: a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset: rstn_i is asynchronous, active-high; clock clk_i.
  - While rstn_i=1: FIFO empty, pointers 0, decimation counter 0, m_valid_o=0, m_data_o=0, level_o=0, ovf_o=0.
- Decimation counter (DEC_W bits), updated only on cycles with en_i=1:
  - cnt==0: the sample is kept; cnt <= (dec_i<=1) ? 0 : dec_i-1.
  - cnt!=0: the sample is discarded; cnt <= cnt-1.
  - A new dec_i value takes effect at the next reload only. The first strobe after reset or clr_i is always kept.
- Write: a kept sample with level<DEPTH is written at wr_ptr, and wr_ptr increments.
  - Kept sample with level==DEPTH and no pop in the same cycle: sample dropped, ovf_o <= 1.
- Read (pop): m_valid_o && m_ready_i.
  - Head is removed; rd_ptr increments.
  - m_ready_i while m_valid_o=0 is ignored.
- Simultaneous push and pop:
  - Any level: both occur and level is unchanged.
  - Full: the push is accepted (no overflow), because the pop frees the slot in the same cycle.
  - Empty: a push cannot coincide with a valid pop, since m_valid_o=0.
- Output timing:
  - m_valid_o = (level!=0), registered.
  - m_data_o is the head entry, registered and updated in the cycle after any push-to-empty or pop.
  - Latency from a kept en_i cycle into an empty FIFO to m_valid_o=1 with that data: 1 clock.
  - m_data_o holds its value while m_valid_o=1 and m_ready_i=0. No data change without a pop.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. level_o tracks the exact count 0..DEPTH.
- clr_i=1 has priority over en_i and pop in the same cycle.
  - Outcome: level=0, pointers 0, cnt=0, ovf_o=0, m_valid_o=0 the next cycle.
  - m_data_o is not required to clear.
- ovf_o stays 1 until clr_i or reset.
- Arithmetic: no transformation of y_i. The sample is stored bit-exact, including wraps from the core's modulo adders.

Optional Feature:
LPFFIR_OUT_STATS_EN
- Defined: adds output drop_cnt_o, 8 bits.
  - Counts kept samples dropped on overflow.
  - Saturates at 255; cleared by reset and clr_i.
- Not defined: the port and counter are absent; ovf_o behaviour is identical.

Test Plan:
1. Basic pass-through: dec_i=1, m_ready_i=1, en_i every cycle, y_i=1,2,3,4 -> m_data_o=1,2,3,4 on consecutive cycles, each 1 cycle after its strobe; level_o never exceeds 1.
2. Decimation: dec_i=3, y_i=10..18 on 9 strobes, m_ready_i=1 -> outputs exactly 10,13,16.
   - Change to dec_i=2 after the 10 is kept: the next kept sample is still 13 (reload semantics).
3. Fill and overflow: m_ready_i=0, dec_i=1, 10 strobes y_i=0x0100..0x0109 -> level_o=8, ovf_o=1, m_data_o=0x0100.
   - Then m_ready_i=1 -> drains 0x0100..0x0107 in order; 0x0108 and 0x0109 are absent. With LPFFIR_OUT_STATS_EN, drop_cnt_o=2.
4. Full with simultaneous push/pop: FIFO full (0..7), a cycle with en_i=1, y_i=0x00AA and m_ready_i=1 -> ovf_o stays 0, level_o stays 8, 0x00AA is drained last.
5. Backpressure stability: level 3, m_ready_i toggling 0/1 per cycle -> m_data_o holds while m_ready_i=0; 3 pops total in order.
6. Clear and reset mid-operation:
   - clr_i asserted with level=5 and en_i=1 in the same cycle -> next cycle level_o=0, m_valid_o=0, ovf_o=0. The first strobe after clr_i is kept regardless of dec_i=4.
   - Asynchronous rstn_i pulse mid-clock -> outputs go to reset values immediately.

Source files
------------

// File: rtl/lpffir_out_buf.sv
// Output buffer for the linear-phase FIR core: decimate, FWFT FIFO, stream.
// Build option LPFFIR_OUT_STATS_EN adds an 8-bit saturating drop counter.
module lpffir_out_buf #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int DEC_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic [DW-1:0]              y_i,
  input  logic [DEC_W-1:0]           dec_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DW-1:0]              m_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
`ifdef LPFFIR_OUT_STATS_EN
  output logic [7:0]                 drop_cnt_o,
`endif
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [LW-1:0]    level_q, level_d;
  logic [DEC_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    data_q, data_d;
  logic             keep, pop, push, drop, full;

  assign full   = (level_q == LW'(DEPTH));
  assign keep   = en_i && (cnt_q == '0);
  assign pop    = valid_q && m_ready_i;
  assign push   = keep && (!full || pop);
  assign drop   = keep && full && !pop;
  assign rd_nxt = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    cnt_d    = cnt_q;
    ovf_d    = ovf_q || drop;
    data_d   = data_q;
    if (en_i) begin
      if (cnt_q == '0)
        cnt_d = (dec_i <= DEC_W'(1)) ? '0 : dec_i - DEC_W'(1);
      else
        cnt_d = cnt_q - DEC_W'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_nxt;
    // The head register always mirrors the entry at rd_ptr.
    if (pop) begin
      if (level_q >= LW'(2)) data_d = mem_q[rd_nxt];
      else if (push)         data_d = y_i;
    end else if (push && level_q == '0) begin
      data_d = y_i;
    end
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      data_d   = data_q;
    end
    valid_d = (level_d != '0);
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem_q[wr_ptr_q] <= y_i;
  end

`ifdef LPFFIR_OUT_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    if (clr_i) drop_cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign level_o   = level_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_lpffir_out_buf.sv
// Directed bench for lpffir_out_buf with hand-computed expectations.
module tb_lpffir_out_buf;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        clr_i = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] y_i = '0;
  logic [3:0]  dec_i = 4'd1;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [15:0] m_data_o;
  logic [3:0]  level_o;
  logic        ovf_o;
`ifdef LPFFIR_OUT_STATS_EN
  logic [7:0]  drop_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  lpffir_out_buf #(.DW(16), .DEPTH(8), .DEC_W(4)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (clr_i),
    .en_i      (en_i),
    .y_i       (y_i),
    .dec_i     (dec_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .level_o   (level_o),
`ifdef LPFFIR_OUT_STATS_EN
    .drop_cnt_o(drop_cnt_o),
`endif
    .ovf_o     (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear();
    en_i = 1'b0; m_ready_i = 1'b0; clr_i = 1'b1;
    step();
    clr_i = 1'b0;
  endtask

  logic [15:0] kept_y [3];
  logic [15:0] exp5 [3];
  int k;

  initial begin
    #2;
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_data", 32'(m_data_o), 0);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    @(negedge clk_i);
    rstn_i = 1'b0;
    step();

    // 1: pass-through
    dec_i = 4'd1; m_ready_i = 1'b1; en_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      y_i = 16'(i);
      step();
      chk("t1_valid", 32'(m_valid_o), 1);
      chk("t1_data", 32'(m_data_o), i);
      chk("t1_level", 32'(level_o), 1);
    end
    en_i = 1'b0;
    step();
    chk("t1_empty", 32'(m_valid_o), 0);

    // 2a: dec=3 keeps 10,13,16
    dec_i = 4'd3; en_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      y_i = 16'(10 + i);
      step();
      chk("t2_valid", 32'(m_valid_o), 32'((i % 3) == 0));
      if ((i % 3) == 0) chk("t2_data", 32'(m_data_o), 10 + i);
    end
    // 2b: dec change takes effect only at the next reload
    kept_y[0] = 16'd13; kept_y[1] = 16'd15;
    y_i = 16'd10;
    step();
    chk("t2b_first", 32'(m_data_o), 10);
    dec_i = 4'd2;
    for (int i = 11; i <= 15; i++) begin
      y_i = 16'(i);
      step();
      chk("t2b_valid", 32'(m_valid_o), 32'(i == 13 || i == 15));
      if (i == 13) chk("t2b_d13", 32'(m_data_o), 13);
      if (i == 15) chk("t2b_d15", 32'(m_data_o), kept_y[1]);
    end
    clear();

    // 3: fill and overflow
    dec_i = 4'd1; m_ready_i = 1'b0; en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      y_i = 16'h0100 + 16'(i);
      step();
      chk("t3_level", 32'(level_o), (i < 8) ? i + 1 : 8);
      chk("t3_ovf", 32'(ovf_o), 32'(i >= 8));
    end
    chk("t3_head", 32'(m_data_o), 32'h0100);
    en_i = 1'b0; m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_dvalid", 32'(m_valid_o), 1);
      chk("t3_drain", 32'(m_data_o), 32'h0100 + i);
      step();
    end
    chk("t3_end_valid", 32'(m_valid_o), 0);
    chk("t3_end_level", 32'(level_o), 0);
    chk("t3_ovf_sticky", 32'(ovf_o), 1);
`ifdef LPFFIR_OUT_STATS_EN
    chk("t3_drops", 32'(drop_cnt_o), 2);
`endif
    clear();
    chk("clr_ovf", 32'(ovf_o), 0);

    // 4: full with simultaneous push/pop
    en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      y_i = 16'(i);
      step();
    end
    chk("t4_full", 32'(level_o), 8);
    y_i = 16'h00AA; m_ready_i = 1'b1;
    step();
    chk("t4_ovf", 32'(ovf_o), 0);
    chk("t4_level", 32'(level_o), 8);
    en_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t4_drain", 32'(m_data_o), (i == 8) ? 32'h00AA : i);
      step();
    end
    chk("t4_empty", 32'(m_valid_o), 0);
    clear();

    // 5: backpressure stability
    exp5[0] = 16'h0031; exp5[1] = 16'h0032; exp5[2] = 16'h0033;
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      y_i = exp5[i];
      step();
    end
    en_i = 1'b0;
    chk("t5_level", 32'(level_o), 3);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      m_ready_i = c[0];
      chk("t5_data", 32'(m_data_o), 32'(exp5[k]));
      step();
      if (c[0]) k++;
    end
    chk("t5_pops", 32'(k), 3);
    chk("t5_empty", 32'(m_valid_o), 0);
    m_ready_i = 1'b0;

    // 6: clear mid-operation with ovf set and level 5
    en_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      y_i = 16'h0050 + 16'(i);
      step();
    end
    en_i = 1'b0; m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    m_ready_i = 1'b0;
    chk("t6_level5", 32'(level_o), 5);
    chk("t6_ovf_set", 32'(ovf_o), 1);
    dec_i = 4'd4; en_i = 1'b1; y_i = 16'h0066; clr_i = 1'b1;
    m_ready_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t6_clr_level", 32'(level_o), 0);
    chk("t6_clr_valid", 32'(m_valid_o), 0);
    chk("t6_clr_ovf", 32'(ovf_o), 0);
    for (int i = 0; i < 5; i++) begin
      y_i = 16'h0077 + 16'(i);
      step();
      chk("t6_keep", 32'(m_valid_o), 32'(i == 0 || i == 4));
      if (i == 0) chk("t6_first", 32'(m_data_o), 32'h0077);
      if (i == 4) chk("t6_fifth", 32'(m_data_o), 32'h007B);
    end

    // async reset pulse between edges
    m_ready_i = 1'b0; y_i = 16'h0099;
    step();
    chk("t6_pre_rst", 32'(m_valid_o), 1);
    #2;
    rstn_i = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid_o), 0);
    chk("arst_level", 32'(level_o), 0);
    chk("arst_data", 32'(m_data_o), 0);
    chk("arst_ovf", 32'(ovf_o), 0);
    en_i = 1'b0;
    #1;
    rstn_i = 1'b0;
    step();
    chk("post_rst", 32'(m_valid_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
